// File: rtl/pulse_param_loader_if.sv
// pulse_param_loader_if: byte stream from the UART receiver into the loader, plus the per-frame result strobes.
// Ports: rx_data/rx_valid (byte and its one-cycle strobe), cmd_ack/cmd_err (one-cycle frame verdict).
// master = byte source / verdict consumer, slave = the loader.
interface pulse_param_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_ack;
  logic       cmd_err;

  modport master (output rx_data, output rx_valid, input cmd_ack, input cmd_err);
  modport slave  (input rx_data, input rx_valid, output cmd_ack, output cmd_err);
endinterface

// File: rtl/pulse_param_loader.sv
// pulse_param_loader: decodes SYNC/ADDR/B0..B3[/CHK] frames into shadow registers; APPLY copies all shadows to live at once.
// Latency: write and cmd_ack/cmd_err land two clk edges after the edge that drives the last byte's strobe.
// No backpressure: rx_valid is always accepted; a byte strobed during COMMIT is decoded as in HUNT.
// Ports: clk, resetn (async active-low), rx (interface slave), live timing outputs per..bl.
// Optional feature: define PARAM_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module pulse_param_loader #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [23:0] TIMEOUT_CYC = 24'd120000,
  parameter logic [31:0] PER_RST     = 32'd200000,
  parameter logic [15:0] WID_RST     = 16'd20,
  parameter logic [15:0] DEL_RST     = 16'd200
) (
  input  logic                clk,
  input  logic                resetn,
  pulse_param_loader_if.slave rx,
  output logic [31:0]         per,
  output logic [15:0]         p1wid,
  output logic [15:0]         del,
  output logic [15:0]         p2wid,
  output logic [15:0]         p1wid2,
  output logic [15:0]         del2,
  output logic [15:0]         p2wid2,
  output logic [15:0]         p1st2,
  output logic [15:0]         nut_d,
  output logic [7:0]          nut_w,
  output logic [6:0]          pr_att,
  output logic                cp,
  output logic                bl
);

  localparam logic [7:0] A_MODE  = 8'h0B;
  localparam logic [7:0] A_APPLY = 8'h0F;

`ifdef PARAM_CHECKSUM_EN
  typedef enum logic [2:0] {S_HUNT, S_ADDR, S_DATA, S_CHK, S_COMMIT} state_t;
`else
  typedef enum logic [2:0] {S_HUNT, S_ADDR, S_DATA, S_COMMIT} state_t;
`endif

  state_t      state, state_nxt;
  logic [7:0]  addr;
  logic [31:0] pay;
  logic [1:0]  bcnt;
  logic [23:0] tmo_cnt;
  logic        chk_bad;
  logic        in_frame, tmo_hit, addr_ok, commit_ok, commit_bad;

  // Shadow copies of every live register.
  logic [31:0] sh_per;
  logic [15:0] sh_p1wid, sh_del, sh_p2wid, sh_p1wid2, sh_del2, sh_p2wid2, sh_p1st2, sh_nut_d;
  logic [7:0]  sh_nut_w;
  logic [6:0]  sh_pr_att;
  logic        sh_cp, sh_bl;

  always_comb begin
    state_nxt  = state;
`ifdef PARAM_CHECKSUM_EN
    in_frame   = (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
`else
    in_frame   = (state == S_ADDR) || (state == S_DATA);
`endif
    // An arriving byte takes priority over an expiring timeout in the same cycle.
    tmo_hit    = in_frame && !rx.rx_valid && (tmo_cnt >= TIMEOUT_CYC - 24'd1);
    addr_ok    = (addr <= A_MODE) || (addr == A_APPLY);
    commit_ok  = (state == S_COMMIT) && addr_ok && !chk_bad;
    commit_bad = (state == S_COMMIT) && !(addr_ok && !chk_bad);

    case (state)
      S_HUNT, S_COMMIT: begin
        // COMMIT behaves like HUNT for incoming bytes so a back-to-back SYNC is not lost.
        if (rx.rx_valid && (rx.rx_data == SYNC_BYTE)) state_nxt = S_ADDR;
        else                                          state_nxt = S_HUNT;
      end
      S_ADDR: if (rx.rx_valid) state_nxt = S_DATA;
      S_DATA: begin
        if (rx.rx_valid && (bcnt == 2'd3)) begin
`ifdef PARAM_CHECKSUM_EN
          state_nxt = S_CHK;
`else
          state_nxt = S_COMMIT;
`endif
        end
      end
`ifdef PARAM_CHECKSUM_EN
      S_CHK:  if (rx.rx_valid) state_nxt = S_COMMIT;
`endif
      default: state_nxt = S_HUNT;
    endcase

    if (tmo_hit) state_nxt = S_HUNT;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_HUNT;
    else         state <= state_nxt;
  end

  // Frame capture and idle timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr    <= 8'd0;
      pay     <= 32'd0;
      bcnt    <= 2'd0;
      tmo_cnt <= 24'd0;
    end else begin
      if (!in_frame || rx.rx_valid) tmo_cnt <= 24'd0;
      else                          tmo_cnt <= tmo_cnt + 24'd1;

      if (rx.rx_valid && (state == S_ADDR)) begin
        addr <= rx.rx_data;
        bcnt <= 2'd0;
      end else if (rx.rx_valid && (state == S_DATA)) begin
        pay[{bcnt, 3'b000} +: 8] <= rx.rx_data;
        bcnt                     <= bcnt + 2'd1;
      end
      if (tmo_hit) bcnt <= 2'd0;
    end
  end

`ifdef PARAM_CHECKSUM_EN
  logic [7:0] chk_acc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      chk_acc <= 8'd0;
      chk_bad <= 1'b0;
    end else if (rx.rx_valid) begin
      case (state)
        S_ADDR: begin
          chk_acc <= rx.rx_data;
          chk_bad <= 1'b0;
        end
        S_DATA:  chk_acc <= chk_acc ^ rx.rx_data;
        S_CHK:   chk_bad <= (rx.rx_data != chk_acc);
        default: ;
      endcase
    end
  end
`else
  assign chk_bad = 1'b0;
`endif

  // Commit: shadow writes, atomic APPLY, and the one-cycle verdict strobes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx.cmd_ack <= 1'b0;
      rx.cmd_err <= 1'b0;
      sh_per <= PER_RST;  sh_p1wid <= WID_RST; sh_del <= DEL_RST;  sh_p2wid <= WID_RST;
      sh_p1wid2 <= WID_RST; sh_del2 <= DEL_RST; sh_p2wid2 <= WID_RST; sh_p1st2 <= 16'd0;
      sh_nut_w <= 8'd0; sh_nut_d <= 16'd0; sh_pr_att <= 7'd0; sh_cp <= 1'b0; sh_bl <= 1'b0;
      per <= PER_RST;  p1wid <= WID_RST; del <= DEL_RST;  p2wid <= WID_RST;
      p1wid2 <= WID_RST; del2 <= DEL_RST; p2wid2 <= WID_RST; p1st2 <= 16'd0;
      nut_w <= 8'd0; nut_d <= 16'd0; pr_att <= 7'd0; cp <= 1'b0; bl <= 1'b0;
    end else begin
      rx.cmd_ack <= commit_ok;
      rx.cmd_err <= commit_bad || tmo_hit;
      if (commit_ok) begin
        case (addr)
          8'h00: sh_per    <= pay;
          8'h01: sh_p1wid  <= pay[15:0];
          8'h02: sh_del    <= pay[15:0];
          8'h03: sh_p2wid  <= pay[15:0];
          8'h04: sh_p1wid2 <= pay[15:0];
          8'h05: sh_del2   <= pay[15:0];
          8'h06: sh_p2wid2 <= pay[15:0];
          8'h07: sh_p1st2  <= pay[15:0];
          8'h08: sh_nut_w  <= pay[7:0];
          8'h09: sh_nut_d  <= pay[15:0];
          8'h0A: sh_pr_att <= pay[6:0];
          A_MODE: begin
            sh_cp <= pay[0];
            sh_bl <= pay[1];
          end
          A_APPLY: begin
            per <= sh_per;  p1wid <= sh_p1wid; del <= sh_del;  p2wid <= sh_p2wid;
            p1wid2 <= sh_p1wid2; del2 <= sh_del2; p2wid2 <= sh_p2wid2; p1st2 <= sh_p1st2;
            nut_w <= sh_nut_w; nut_d <= sh_nut_d; pr_att <= sh_pr_att; cp <= sh_cp; bl <= sh_bl;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
